c2h_packetizer: RTL and testbench

- Sits directly downstream of the NWRITE receive engine's C2H stream output, between that engine and the XDMA C2H AXI-Stream port.
- The upstream engine emits byte-swapped 64-bit beats with tlast tied low. This block adds packet framing for XDMA, so that each C2H DMA descriptor completes.
- Framing rules: tlast is asserted after a programmable beat count, on a partial-keep beat, on upstream tlast, on an explicit flush, or (optionally) after an idle timeout.
- One beat is always held back, so that tlast can be attached to it once the packet end becomes known.

---
 rtl/c2h_pkg.sv | 23 ++
 rtl/c2h_out_slice.sv | 37 +++
 rtl/c2h_packetizer.sv | 149 ++++++++++++++
 tb/tb_c2h_packetizer.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c2h_pkg.sv
// c2h_pkg: shared widths, beat bundle and helpers for the C2H packetizer.
package c2h_pkg;

  localparam int C_TDATA_W = 64;
  localparam int C_TKEEP_W = 8;

  localparam logic [C_TKEEP_W-1:0] C_KEEP_FULL = 8'hFF;

  typedef struct packed {
    logic [C_TDATA_W-1:0] data;
    logic [C_TKEEP_W-1:0] keep;
    logic                 last;
  } c2h_beat_t;

  // Ceiling log2 with a floor of 1 so a counter never collapses to 0 bits.
  function automatic int clog2(input int unsigned v);
    int r;
    r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/c2h_out_slice.sv
// c2h_out_slice: output register O driving m_axis, with the
// tlast-handshake pulse used for packet counting.
module c2h_out_slice
  import c2h_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_load,
  input  c2h_beat_t i_beat,
  input  logic      i_ready,
  output logic      o_valid,
  output c2h_beat_t o_beat,
  output logic      o_free,
  output logic      o_last_hs
);

  logic      r_valid;
  c2h_beat_t r_beat;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_beat  <= i_beat;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_free    = !r_valid || i_ready;
  assign o_last_hs = r_valid && i_ready && r_beat.last;
  assign o_valid   = r_valid;
  assign o_beat    = r_beat;

endmodule

// File: rtl/c2h_packetizer.sv
// c2h_packetizer: frames the NWRITE C2H beat stream with tlast for XDMA.
// Optional idle flush of a held beat: define C2H_IDLE_FLUSH_EN.
module c2h_packetizer
  import c2h_pkg::*;
#(
  parameter int C_CNT_WIDTH    = 16,
  parameter int C_IDLE_TIMEOUT = 1024,
  parameter int C_PKTCNT_WIDTH = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [C_CNT_WIDTH-1:0]    pkt_beats,
  input  logic                      flush,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [C_TDATA_W-1:0]      s_axis_tdata,
  input  logic [C_TKEEP_W-1:0]      s_axis_tkeep,
  input  logic                      s_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [C_TDATA_W-1:0]      m_axis_tdata,
  output logic [C_TKEEP_W-1:0]      m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [C_PKTCNT_WIDTH-1:0] pkt_count,
  output logic                      busy
);

  logic                      r_en;
  logic                      r_h_valid;
  c2h_beat_t                 r_h;
  logic [C_CNT_WIDTH-1:0]    r_beat_cnt;
  logic [C_CNT_WIDTH-1:0]    r_len;
  logic [C_PKTCNT_WIDTH-1:0] r_pkt_count;

  logic                      w_o_valid;
  logic                      w_o_free;
  logic                      w_last_hs;
  c2h_beat_t                 w_o_beat;
  c2h_beat_t                 w_in_beat;
  logic                      w_accept;
  logic                      w_h_move;
  logic                      w_flush;
  logic                      w_idle_hit;
  logic                      w_last_in;
  logic                      w_h_flush;
  logic [C_CNT_WIDTH-1:0]    w_len_in;
  logic [C_CNT_WIDTH-1:0]    w_len;
  logic [C_CNT_WIDTH:0]      w_cnt_nxt;

  // r_en keeps tready low for the first cycle out of reset.
  assign s_axis_tready = r_en && (!r_h_valid || w_o_free);
  assign w_accept  = s_axis_tvalid && s_axis_tready;
  assign w_h_move  = r_h_valid && w_o_free && (r_h.last || w_accept);
  assign w_flush   = flush || w_idle_hit;
  assign w_h_flush = w_flush && r_h_valid && !w_accept;

  assign w_len_in  = (pkt_beats == '0) ? C_CNT_WIDTH'(1) : pkt_beats;
  assign w_len     = (r_beat_cnt == '0) ? w_len_in : r_len;
  assign w_cnt_nxt = {1'b0, r_beat_cnt} + (C_CNT_WIDTH+1)'(1);

  assign w_last_in = (w_cnt_nxt == {1'b0, w_len})
                  || (s_axis_tkeep != C_KEEP_FULL)
                  || s_axis_tlast
                  || w_flush;

  assign w_in_beat = '{data: s_axis_tdata,
                       keep: s_axis_tkeep,
                       last: w_last_in};

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_en       <= 1'b0;
      r_h_valid  <= 1'b0;
      r_h        <= '0;
      r_beat_cnt <= '0;
      r_len      <= '0;
    end else begin
      r_en <= 1'b1;
      if (w_accept) begin
        r_h_valid <= 1'b1;
        r_h       <= w_in_beat;
      end else if (w_h_move) begin
        r_h_valid <= 1'b0;
      end else if (w_h_flush) begin
        r_h.last  <= 1'b1;
      end
      if (w_accept) begin
        r_beat_cnt <= w_last_in ? '0
                    : r_beat_cnt + C_CNT_WIDTH'(1);
        if (r_beat_cnt == '0) r_len <= w_len_in;
      end else if (w_h_flush) begin
        r_beat_cnt <= '0;
      end
    end
  end

`ifdef C2H_IDLE_FLUSH_EN
  localparam int C_IDLE_W = clog2(C_IDLE_TIMEOUT);

  logic [C_IDLE_W-1:0] r_idle_cnt;
  logic                w_idle_run;

  assign w_idle_run = r_h_valid && !r_h.last && !w_accept;
  assign w_idle_hit = w_idle_run
    && (r_idle_cnt == C_IDLE_W'(C_IDLE_TIMEOUT-1));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_idle_cnt <= '0;
    end else if (!w_idle_run || w_flush) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + C_IDLE_W'(1);
    end
  end
`else
  logic w_unused_idle;
  assign w_unused_idle = (C_IDLE_TIMEOUT != 0);
  assign w_idle_hit    = 1'b0;
`endif

  c2h_out_slice u_out (
    .i_clk     (aclk),
    .i_rst_n   (aresetn),
    .i_load    (w_h_move),
    .i_beat    (r_h),
    .i_ready   (m_axis_tready),
    .o_valid   (w_o_valid),
    .o_beat    (w_o_beat),
    .o_free    (w_o_free),
    .o_last_hs (w_last_hs)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_pkt_count <= '0;
    end else if (w_last_hs) begin
      r_pkt_count <= r_pkt_count + C_PKTCNT_WIDTH'(1);
    end
  end

  assign m_axis_tvalid = w_o_valid;
  assign m_axis_tdata  = w_o_beat.data;
  assign m_axis_tkeep  = w_o_beat.keep;
  assign m_axis_tlast  = w_o_beat.last;
  assign pkt_count     = r_pkt_count;
  assign busy          = r_h_valid || w_o_valid;

endmodule

// File: tb/tb_c2h_packetizer.sv
// tb_c2h_packetizer: directed stimulus with a queue-based framing model
// checked against the m_axis stream every cycle.
`timescale 1ns/1ps
module tb_c2h_packetizer;

  localparam int T_IDLE = 16;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } ebeat_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] pkt_beats = '0;
  logic        flush = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0;
  logic        m_tvalid;
  logic        m_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;
  logic [31:0] pkt_count;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;
  int tr_mode = 0;
  int stalls = 0;
  int vcyc = 0;

  ebeat_t      q[$];
  int          mcnt = 0;
  logic [15:0] mlen = '0;
  logic [31:0] mpkts = '0;
  int          idle = 0;
  logic [63:0] lastlog = '0;
  int          nlog = 0;
  logic [7:0]  last_keep = '0;

  c2h_packetizer #(
    .C_CNT_WIDTH    (16),
    .C_IDLE_TIMEOUT (T_IDLE),
    .C_PKTCNT_WIDTH (32)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .pkt_beats     (pkt_beats),
    .flush         (flush),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .pkt_count     (pkt_count),
    .busy          (busy)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Downstream ready: 0 = always 1, 1 = always 0, 2 = toggling.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      case (tr_mode)
        0: m_tready = 1'b1;
        1: m_tready = 1'b0;
        default: m_tready = ~m_tready;
      endcase
    end
  end

  // Model: framing rules applied to the accepted stream; the newest
  // non-last beat is the one a flush or timeout closes.
  always @(negedge aclk) begin : mon
    ebeat_t      e;
    logic        acc;
    logic        fl;
    logic        lst;
    logic [15:0] len;
    if (!aresetn) begin
      q.delete();
      mcnt  = 0;
      mlen  = '0;
      mpkts = '0;
      idle  = 0;
    end else begin
      chk("pkt_count", pkt_count, mpkts);
      chk("busy", busy, q.size() != 0);
      if (m_tvalid) vcyc++;
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) begin
          chk("spurious_beat", {63'b0, m_tvalid}, 64'd0);
        end else begin
          e = q.pop_front();
          chk("tdata", m_tdata, e.d);
          chk("tkeep", m_tkeep, e.k);
          chk("tlast", m_tlast, e.l);
          if (e.l) mpkts++;
          lastlog = {lastlog[62:0], m_tlast};
          nlog++;
          if (m_tlast) last_keep = m_tkeep;
        end
      end
      acc = s_tvalid && s_tready;
      fl  = flush;
`ifdef C2H_IDLE_FLUSH_EN
      if (!acc && !fl && q.size() != 0 && !q[q.size()-1].l) begin
        if (idle == T_IDLE-1) begin
          fl   = 1'b1;
          idle = 0;
        end else begin
          idle++;
        end
      end else begin
        idle = 0;
      end
`endif
      if (acc) begin
        if (mcnt == 0) begin
          mlen = (pkt_beats == 16'd0) ? 16'd1 : pkt_beats;
        end
        len = mlen;
        lst = (mcnt + 1 == int'(len)) || (s_tkeep != 8'hFF)
           || s_tlast || fl;
        e.d = s_tdata;
        e.k = s_tkeep;
        e.l = lst;
        q.push_back(e);
        mcnt = lst ? 0 : mcnt + 1;
      end else if (fl && q.size() != 0 && !q[q.size()-1].l) begin
        q[q.size()-1].l = 1'b1;
        mcnt = 0;
      end
    end
  end

  function automatic logic [63:0] mk(input int t, input int i);
    return {8'(t), 24'hC2D4E6, 32'(i)};
  endfunction

  task automatic send(input logic [63:0] d, input logic [7:0] k,
                      input logic l);
    logic ok;
    int   n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    n = 0;
    forever begin
      @(negedge aclk);
      ok = s_tready;
      @(posedge aclk); #1;
      if (ok) break;
      n++;
      stalls++;
      if (n >= 50) begin
        chk("send_timeout", 64'(n), 64'd0);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 200) begin
      @(posedge aclk); #1;
      n++;
    end
    chk("drain_timeout", 64'(n >= 200), 64'd0);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge aclk); #1;
    flush = 1'b0;
  endtask

  task automatic clr_log();
    lastlog = '0;
    nlog    = 0;
    stalls  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int v0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_busy", busy, 0);
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // 8 back-to-back beats, length 4
    pkt_beats = 16'd4;
    clr_log();
    for (int i = 0; i < 8; i++) send(mk(1, i), 8'hFF, 1'b0);
    chk("t1_stalls", 64'(stalls), 0);
    drain();
    chk("t1_pkt_count", pkt_count, 2);
    chk("t1_nbeats", 64'(nlog), 8);
    chk("t1_last_pos", lastlog[7:0], 8'b0001_0001);

    // partial keep ends a 16-beat packet early; count restarts
    pkt_beats = 16'd16;
    clr_log();
    send(mk(2, 0), 8'hFF, 1'b0);
    send(mk(2, 1), 8'hFF, 1'b0);
    send(mk(2, 2), 8'h0F, 1'b0);
    drain();
    chk("t2_pkt_count", pkt_count, 3);
    chk("t2_last_keep", last_keep, 8'h0F);
    chk("t2_last_pos", lastlog[2:0], 3'b001);
    pkt_beats = 16'd2;
    clr_log();
    send(mk(2, 3), 8'hFF, 1'b0);
    send(mk(2, 4), 8'hFF, 1'b0);
    drain();
    chk("t2_restart", lastlog[1:0], 2'b01);
    chk("t2_pkt_count2", pkt_count, 4);

    // length 0 means 1
    pkt_beats = 16'd0;
    clr_log();
    send(mk(3, 0), 8'hFF, 1'b0);
    send(mk(3, 1), 8'hFF, 1'b0);
    drain();
    chk("t3_last_pos", lastlog[1:0], 2'b11);
    chk("t3_pkt_count", pkt_count, 6);

    // upstream tlast honoured
    pkt_beats = 16'd8;
    clr_log();
    send(mk(3, 2), 8'hFF, 1'b1);
    drain();
    chk("t3_tlast_in", lastlog[0], 1);
    chk("t3_pkt_count2", pkt_count, 7);

    // flush closes the held beat
    clr_log();
    send(mk(4, 0), 8'hFF, 1'b0);
    send(mk(4, 1), 8'hFF, 1'b0);
    repeat (5) @(posedge aclk);
    #1;
    chk("t4_held_busy", busy, 1);
    chk("t4_held_tvalid", m_tvalid, 0);
    pulse_flush();
    n = 0;
    while (!(m_tvalid && m_tlast) && n < 4) begin
      @(posedge aclk); #1;
      n++;
    end
    chk("t4_flush_lat", 64'(n >= 1 && n <= 2), 1);
    drain();
    chk("t4_last_pos", lastlog[1:0], 2'b01);
    chk("t4_pkt_count", pkt_count, 8);
    v0 = vcyc;
    pulse_flush();
    repeat (5) @(posedge aclk);
    #1;
    chk("t4_empty_flush", 64'(vcyc - v0), 0);
    chk("t4_empty_busy", busy, 0);

    // back-pressure: O full, H full -> upstream stalled
    tr_mode = 1;
    repeat (2) @(posedge aclk);
    #1;
    pkt_beats = 16'd4;
    clr_log();
    send(mk(5, 0), 8'hFF, 1'b0);
    send(mk(5, 1), 8'hFF, 1'b0);
    chk("t5_bp_tready", s_tready, 0);
    chk("t5_bp_tvalid", m_tvalid, 1);
    chk("t5_bp_tdata", m_tdata, mk(5, 0));
    pulse_flush();
    tr_mode = 0;
    drain();
    chk("t5_bp_last", lastlog[1:0], 2'b01);
    chk("t5_pkt_count", pkt_count, 9);

    // toggling downstream ready over 12 beats
    tr_mode = 2;
    clr_log();
    for (int i = 0; i < 12; i++) send(mk(6, i), 8'hFF, 1'b0);
    drain();
    tr_mode = 0;
    chk("t6_nbeats", 64'(nlog), 12);
    chk("t6_last_pos", lastlog[11:0], 12'b0001_0001_0001);
    chk("t6_pkt_count", pkt_count, 12);

    // reset mid-packet
    tr_mode = 1;
    repeat (2) @(posedge aclk);
    #1;
    send(mk(7, 0), 8'hFF, 1'b0);
    send(mk(7, 1), 8'hFF, 1'b0);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    chk("t7_tvalid", m_tvalid, 0);
    chk("t7_tdata", m_tdata, 0);
    chk("t7_tkeep", m_tkeep, 0);
    chk("t7_tlast", m_tlast, 0);
    chk("t7_tready", s_tready, 0);
    chk("t7_pkt_count", pkt_count, 0);
    chk("t7_busy", busy, 0);
    aresetn = 1'b1;
    tr_mode = 0;
    repeat (2) @(posedge aclk);
    #1;

    // single beat then idle
    pkt_beats = 16'd8;
    clr_log();
    v0 = vcyc;
    send(mk(8, 0), 8'hFF, 1'b0);
`ifdef C2H_IDLE_FLUSH_EN
    n = 0;
    while (!m_tvalid && n < 40) begin
      @(posedge aclk); #1;
      n++;
    end
    chk("t8_idle_lat", 64'(n >= T_IDLE-1 && n <= T_IDLE+2), 1);
    drain();
`else
    repeat (100) @(posedge aclk);
    #1;
    chk("t8_no_output", 64'(vcyc - v0), 0);
    chk("t8_still_busy", busy, 1);
    pulse_flush();
    drain();
`endif
    chk("t8_last", lastlog[0], 1);
    chk("t8_pkt_count", pkt_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
